// File: rtl/dup_dealer_if.sv
// Player/judge-facing signals of the double-up dealer.
// The master side is the environment that presses buttons and judges; the slave side is the dealer.
interface dup_dealer_if;
   logic        bet_c;
   logic        start;
   logic [15:0] base_pay;
   logic        btn_high;
   logic        btn_low;
   logic        btn_take;
   logic [1:0]  highlow_r;
   logic [3:0]  Dnum0;
   logic [3:0]  Dnum1;
   logic [1:0]  highlow;
   logic [15:0] payout;
   logic [1:0]  rounds;
   logic        busy;
   logic        done;
   logic        lost;

   modport master (
      output bet_c, start, base_pay, btn_high, btn_low, btn_take, highlow_r,
      input  Dnum0, Dnum1, highlow, payout, rounds, busy, done, lost
   );

   modport slave (
      input  bet_c, start, base_pay, btn_high, btn_low, btn_take, highlow_r,
      output Dnum0, Dnum1, highlow, payout, rounds, busy, done, lost
   );
endinterface

// File: rtl/dup_dealer.sv
// Double-up card dealer: deals two cards from a free-running LFSR, takes a high/low guess,
// asks an external judge for a verdict and doubles or holds the stake for up to three rounds.
//
// state | meaning
// IDLE  | no session; waiting for start
// DRAW0 | drawing the face-up card
// DRAW1 | drawing the hidden card
// WAIT  | waiting for a player button
// ISSUE | guess presented to the judge for one cycle
// EVAL  | consuming the judge verdict
// DONE  | one-cycle end-of-session pulse
module dup_dealer (
   input logic         clock,
   input logic         reset_c,
   dup_dealer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAW0 = 3'd1,
      DRAW1 = 3'd2,
      WAIT  = 3'd3,
      ISSUE = 3'd4,
      EVAL  = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t      state;
   logic [7:0]  lfsr;
   logic        eval_wait;
   logic        card_ok;
   logic [15:0] doubled;
   logic [1:0]  rounds_inc;

   // Only 1..13 is a legal card; 0, 14 and 15 cause a retry on the next LFSR value.
   assign card_ok    = (lfsr[3:0] != 4'd0) && (lfsr[3:0] <= 4'd13);
   assign doubled    = bus.payout[15] ? 16'hFFFF : {bus.payout[14:0], 1'b0};
   assign rounds_inc = bus.rounds + 2'd1;

   always_ff @(posedge clock or negedge reset_c) begin
      if (!reset_c) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   always_ff @(posedge clock or negedge reset_c) begin
      if (!reset_c) begin
         state       <= IDLE;
         eval_wait   <= 1'b0;
         bus.Dnum0   <= 4'd0;
         bus.Dnum1   <= 4'd0;
         bus.highlow <= 2'b00;
         bus.payout  <= 16'd0;
         bus.rounds  <= 2'd0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.lost    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (!bus.bet_c) begin
            // Abort: silent return to IDLE, stake forfeited, no end pulse.
            state       <= IDLE;
            eval_wait   <= 1'b0;
            bus.highlow <= 2'b00;
            bus.payout  <= 16'd0;
            bus.rounds  <= 2'd0;
            bus.busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     state      <= DRAW0;
                     bus.payout <= bus.base_pay;
                     bus.rounds <= 2'd0;
                     bus.lost   <= 1'b0;
                     bus.Dnum0  <= 4'd0;
                     bus.Dnum1  <= 4'd0;
                     bus.busy   <= 1'b1;
                  end
               end
               DRAW0: begin
                  if (card_ok) begin
                     bus.Dnum0 <= lfsr[3:0];
                     state     <= DRAW1;
                  end
               end
               DRAW1: begin
                  if (card_ok) begin
                     bus.Dnum1 <= lfsr[3:0];
                     state     <= WAIT;
                  end
               end
               WAIT: begin
                  if (bus.btn_take) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else if (bus.btn_high && !bus.btn_low) begin
                     bus.highlow <= 2'b01;
                     state       <= ISSUE;
                  end else if (bus.btn_low && !bus.btn_high) begin
                     bus.highlow <= 2'b10;
                     state       <= ISSUE;
                  end
               end
               ISSUE: begin
                  bus.highlow <= 2'b00;
                  eval_wait   <= 1'b0;
                  state       <= EVAL;
               end
               EVAL: begin
                  if (bus.highlow_r == 2'b01 || bus.highlow_r == 2'b10) begin
                     if (bus.highlow_r == 2'b01) begin
                        bus.payout <= doubled;
                     end
                     bus.rounds <= rounds_inc;
                     if (rounds_inc == 2'd3) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                     end else begin
                        // The hidden card becomes the next face-up card.
                        bus.Dnum0 <= bus.Dnum1;
                        bus.Dnum1 <= 4'd0;
                        state     <= DRAW1;
                     end
                  end else if (bus.highlow_r == 2'b00 && !eval_wait) begin
                     eval_wait <= 1'b1;
                  end else begin
                     // Explicit loss, or judge silent for two cycles.
                     bus.payout <= 16'd0;
                     bus.lost   <= 1'b1;
                     state      <= DONE;
                     bus.done   <= 1'b1;
                  end
               end
               DONE: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
               default: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
